// File: rtl/lut_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : lut_cfg_loader
//  Purpose  : Serial configuration loader for frac_lut6. Bits arrive on
//             ccff_head under a valid/ready handshake and are assembled into
//             a shadow register. A complete load is then committed atomically
//             to the active register, so the LUT never sees a half-loaded
//             truth table.
//  Ports    : prog_clk        - configuration clock (the only clock)
//             pReset          - synchronous active-high reset
//             cfg_start       - one-cycle pulse: begin or restart a load
//             ccff_head       - serial configuration bit
//             ccff_head_valid - ccff_head carries a bit this cycle
//             ccff_head_ready - loader takes a bit this cycle
//             sram/sram_inv   - active truth table and its inverse
//             mode/mode_inv   - active fracture-mode bits and their inverse
//             cfg_busy        - load or commit in progress
//             cfg_done        - one-cycle pulse when the active register updates
//             cfg_err         - sticky parity failure flag
//  Options  : LUT_CFG_PARITY_EN - adds a trailing even-parity bit to the
//             stream; a failing load is rejected and raises cfg_err.
//             Without it cfg_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module lut_cfg_loader #(
    parameter int SRAM_W = 64,
    parameter int MODE_W = 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic              ccff_head,
    input  logic              ccff_head_valid,
    output logic              ccff_head_ready,
    output logic [SRAM_W-1:0] sram,
    output logic [SRAM_W-1:0] sram_inv,
    output logic [MODE_W-1:0] mode,
    output logic [MODE_W-1:0] mode_inv,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int N = SRAM_W + MODE_W;
`ifdef LUT_CFG_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    // The counter must be able to hold L itself (the drain value below).
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] C_CNT_FULL = CW'(L);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [L-1:0]    r_shadow;
    logic [N-1:0]    r_active;
    logic            r_done;
    logic            w_ready;
    logic            w_accept;
    logic            w_parity_ok;

`ifdef LUT_CFG_PARITY_EN
    logic            r_err;
    // Even parity: the XOR of every stream bit, parity bit included, is 0.
    assign w_parity_ok = ~(^r_shadow);
    assign cfg_err     = r_err;
`else
    assign w_parity_ok = 1'b1;
    assign cfg_err     = 1'b0;
`endif

    assign w_accept = ccff_head_valid & w_ready;

    // ------------------------------------------------------------------------
    // Next-state and handshake decode.
    // After the last bit the counter sits at L for one drain cycle (ready low,
    // still in LOAD) before COMMIT; this places the commit edge two edges
    // after the final accept.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = (r_cnt != C_CNT_FULL);
                if (!cfg_start && (r_cnt == C_CNT_FULL)) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter, shadow and active registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_done   <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_cnt <= '0;
`ifdef LUT_CFG_PARITY_EN
                        r_err <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // A restart wins over a bit offered in the same cycle;
                    // stale shadow contents are simply overwritten.
                    if (cfg_start) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_shadow[r_cnt] <= ccff_head;
                        r_cnt           <= r_cnt + CW'(1);
                    end
                end
                S_COMMIT: begin
                    if (w_parity_ok) begin
                        r_active <= r_shadow[N-1:0];
                        r_done   <= 1'b1;
                    end else begin
`ifdef LUT_CFG_PARITY_EN
                        r_err    <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Inverted rails are derived combinationally from the same
    // register so they can never be skewed against the true rails.
    // ------------------------------------------------------------------------
    assign ccff_head_ready = w_ready;
    assign sram            = r_active[SRAM_W-1:0];
    assign mode            = r_active[N-1:SRAM_W];
    assign sram_inv        = ~r_active[SRAM_W-1:0];
    assign mode_inv        = ~r_active[N-1:SRAM_W];
    assign cfg_busy        = (r_state == S_LOAD) || (r_state == S_COMMIT);
    assign cfg_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_cfg_loader
//  Purpose  : Directed self-checking bench for lut_cfg_loader: reset state,
//             full load and commit latency, valid gaps, restart, reset during
//             a load and (with LUT_CFG_PARITY_EN) parity rejection.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lut_cfg_loader;

`ifdef LUT_CFG_PARITY_EN
    localparam int L = 66;
`else
    localparam int L = 65;
`endif

    logic        prog_clk;
    logic        pReset;
    logic        cfg_start;
    logic        ccff_head;
    logic        ccff_head_valid;
    logic        ccff_head_ready;
    logic [63:0] sram;
    logic [63:0] sram_inv;
    logic [0:0]  mode;
    logic [0:0]  mode_inv;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    int d0;

    logic [65:0] stream_a;
    logic [65:0] stream_b;
    logic [65:0] stream_bad;

    lut_cfg_loader #(.SRAM_W(64), .MODE_W(1)) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .cfg_start       (cfg_start),
        .ccff_head       (ccff_head),
        .ccff_head_valid (ccff_head_valid),
        .ccff_head_ready (ccff_head_ready),
        .sram            (sram),
        .sram_inv        (sram_inv),
        .mode            (mode),
        .mode_inv        (mode_inv),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Done pulses counted away from the active edge.
    always @(negedge prog_clk) begin
        if (cfg_done === 1'b1) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Stream bit k is shadow bit k; with parity, bit 65 makes the total even.
    function automatic logic [65:0] mk_stream(input logic [64:0] d);
        logic [65:0] s;
        s = {1'b0, d};
`ifdef LUT_CFG_PARITY_EN
        s[65] = ^d;
`endif
        return s;
    endfunction

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Offers n bits; returns after the edge that accepts the last one.
    task automatic send(input logic [65:0] d, input int n, input bit gaps, input string tag);
        int k;
        int guard;
        bit acc;
        k = 0;
        guard = 0;
        while ((k < n) && (guard < 1000)) begin
            if (gaps && (guard % 2 == 1)) begin
                ccff_head_valid = 1'b0;
            end else begin
                ccff_head_valid = 1'b1;
                ccff_head       = d[k];
            end
            if (gaps) chk({tag, "_ready_in_load"}, {63'd0, ccff_head_ready}, 64'd1);
            acc = ccff_head_valid & ccff_head_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        ccff_head_valid = 1'b0;
        chk({tag, "_bits_accepted"}, 64'(k), 64'(n));
    endtask

    initial begin
        pReset = 1'b1; cfg_start = 1'b0; ccff_head = 1'b0; ccff_head_valid = 1'b0;
        stream_a = mk_stream({1'b1, 64'h8000_0000_0000_0001});
        stream_b = mk_stream({1'b0, 64'h0123_4567_89AB_CDEF});

        // 1: reset state
        tick(); tick();
        pReset = 1'b0;
        chk("rst_sram",     sram,     64'h0);
        chk("rst_sram_inv", sram_inv, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mode",     {63'd0, mode},     64'd0);
        chk("rst_mode_inv", {63'd0, mode_inv}, 64'd1);
        chk("rst_busy",     {63'd0, cfg_busy}, 64'd0);
        chk("rst_ready",    {63'd0, ccff_head_ready}, 64'd0);
        chk("rst_done",     {63'd0, cfg_done}, 64'd0);
        chk("rst_err",      {63'd0, cfg_err},  64'd0);

        // valid while idle is ignored
        ccff_head_valid = 1'b1; ccff_head = 1'b1;
        tick(); tick();
        chk("idle_ready", {63'd0, ccff_head_ready}, 64'd0);
        chk("idle_sram",  sram, 64'h0);
        ccff_head_valid = 1'b0;

        // 2: full load, valid always high, commit two edges after last accept
        pulse_start();
        chk("load_busy", {63'd0, cfg_busy}, 64'd1);
        send(stream_a, L, 1'b0, "full");
        chk("full_e0_done", {63'd0, cfg_done}, 64'd0);
        chk("full_e0_sram", sram, 64'h0);
        chk("full_e0_ready", {63'd0, ccff_head_ready}, 64'd0);
        tick();
        chk("full_e1_done", {63'd0, cfg_done}, 64'd0);
        chk("full_e1_sram", sram, 64'h0);
        chk("full_e1_busy", {63'd0, cfg_busy}, 64'd1);
        tick();
        chk("full_e2_done", {63'd0, cfg_done}, 64'd1);
        chk("full_sram",     sram,     64'h8000_0000_0000_0001);
        chk("full_sram_inv", sram_inv, 64'h7FFF_FFFF_FFFF_FFFE);
        chk("full_mode",     {63'd0, mode},     64'd1);
        chk("full_mode_inv", {63'd0, mode_inv}, 64'd0);
        chk("full_e2_busy",  {63'd0, cfg_busy}, 64'd0);
        tick();
        chk("full_e3_done", {63'd0, cfg_done}, 64'd0);

        // 4: restart mid-load; the bit offered with the restart is dropped
        d0 = n_done;
        pulse_start();
        send(stream_a, 30, 1'b0, "rst30");
        cfg_start = 1'b1; ccff_head_valid = 1'b1; ccff_head = 1'b1;
        tick();
        cfg_start = 1'b0; ccff_head_valid = 1'b0;
        send(stream_b, L, 1'b0, "restart");
        tick(); tick();
        chk("restart_sram", sram, 64'h0123_4567_89AB_CDEF);
        chk("restart_mode", {63'd0, mode}, 64'd0);
        tick(); tick();
        chk("restart_done_count", 64'(n_done - d0), 64'd1);

        // 3: same stream A with valid gaps
        pulse_start();
        send(stream_a, L, 1'b1, "gaps");
        tick(); tick();
        chk("gaps_done", {63'd0, cfg_done}, 64'd1);
        chk("gaps_sram", sram, 64'h8000_0000_0000_0001);
        chk("gaps_mode", {63'd0, mode}, 64'd1);

        // 5: reset during a load
        tick();
        d0 = n_done;
        pulse_start();
        send(stream_b, 40, 1'b0, "midrst");
        pReset = 1'b1;
        tick(); tick();
        pReset = 1'b0;
        chk("midrst_sram",     sram, 64'h0);
        chk("midrst_sram_inv", sram_inv, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("midrst_mode",     {63'd0, mode}, 64'd0);
        chk("midrst_busy",     {63'd0, cfg_busy}, 64'd0);
        chk("midrst_ready",    {63'd0, ccff_head_ready}, 64'd0);
        tick(); tick(); tick();
        chk("midrst_no_done",  64'(n_done - d0), 64'd0);
        chk("midrst_sram_hold", sram, 64'h0);

`ifdef LUT_CFG_PARITY_EN
        // 6: parity rejection keeps the old table and raises a sticky error
        pulse_start();
        send(stream_a, L, 1'b0, "par_good");
        tick(); tick();
        chk("par_good_sram", sram, 64'h8000_0000_0000_0001);
        chk("par_good_err",  {63'd0, cfg_err}, 64'd0);
        tick();
        d0 = n_done;
        stream_bad = stream_b;
        stream_bad[5] = ~stream_bad[5];
        pulse_start();
        send(stream_bad, L, 1'b0, "par_bad");
        tick(); tick();
        chk("par_bad_err",  {63'd0, cfg_err},  64'd1);
        chk("par_bad_done", {63'd0, cfg_done}, 64'd0);
        chk("par_bad_sram", sram, 64'h8000_0000_0000_0001);
        chk("par_bad_mode", {63'd0, mode}, 64'd1);
        tick(); tick();
        chk("par_err_sticky", {63'd0, cfg_err}, 64'd1);
        chk("par_bad_no_done", 64'(n_done - d0), 64'd0);
        pulse_start();
        chk("par_err_cleared", {63'd0, cfg_err}, 64'd0);
        send(stream_b, L, 1'b0, "par_reload");
        tick(); tick();
        chk("par_reload_sram", sram, 64'h0123_4567_89AB_CDEF);
        chk("par_reload_done", {63'd0, cfg_done}, 64'd1);
`else
        chk("noparity_err", {63'd0, cfg_err}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
